// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared
// single-port memory.
interface mem_port_arbiter_if;
  logic        IReq;
  logic [31:0] IAddr;
  logic        DReq;
  logic [31:0] DAddr;
  logic [31:0] DWrData;
  logic        DWrite;
  logic [1:0]  DMemType;
  logic [31:0] MemRdData;
  logic [31:0] MemAddr;
  logic [31:0] MemWrData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemType;
  logic        IValid;
  logic [31:0] IRdData;
  logic        DValid;
  logic [31:0] DRdData;
  logic        StallF;
  logic        StallM;

  // Arbiter side: takes requests and memory read data, drives memory and completions.
  modport slave (
    input  IReq, IAddr, DReq, DAddr, DWrData, DWrite, DMemType, MemRdData,
    output MemAddr, MemWrData, MemRead, MemWrite, MemType,
           IValid, IRdData, DValid, DRdData, StallF, StallM
  );

  // Requester/memory side.
  modport master (
    output IReq, IAddr, DReq, DAddr, DWrData, DWrite, DMemType, MemRdData,
    input  MemAddr, MemWrData, MemRead, MemWrite, MemType,
           IValid, IRdData, DValid, DRdData, StallF, StallM
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory with a fixed
// response latency; data side wins unless fetch has lost two grants in a row.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input logic Clk,
  input logic Reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

  state_t     state;
  state_t     nextState;
  logic [3:0] latCnt;
  logic [1:0] dStreak;
  logic       grantI;
  logic       grantD;
  logic       done;

  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // Fetch is forced through after two consecutive contested data grants.
        if (bus.DReq && !(bus.IReq && dStreak == 2'd2)) begin
          grantD    = 1'b1;
          nextState = BUSY_D;
        end else if (bus.IReq) begin
          grantI    = 1'b1;
          nextState = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (latCnt == 4'd0) begin
          done      = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      latCnt        <= 4'd0;
      dStreak       <= 2'd0;
      bus.MemAddr   <= 32'd0;
      bus.MemWrData <= 32'd0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.MemType   <= 2'b00;
      bus.IValid    <= 1'b0;
      bus.IRdData   <= 32'd0;
      bus.DValid    <= 1'b0;
      bus.DRdData   <= 32'd0;
    end else begin
      state      <= nextState;
      bus.IValid <= 1'b0;
      bus.DValid <= 1'b0;
      if (grantI) begin
        bus.MemAddr   <= bus.IAddr;
        bus.MemWrData <= 32'd0;
        bus.MemType   <= 2'b00;
        bus.MemRead   <= 1'b1;
        bus.MemWrite  <= 1'b0;
        latCnt        <= LatLoad;
        dStreak       <= 2'd0;
      end else if (grantD) begin
        bus.MemAddr   <= bus.DAddr;
        bus.MemWrData <= bus.DWrData;
        bus.MemType   <= bus.DMemType;
        bus.MemRead   <= ~bus.DWrite;
        bus.MemWrite  <= bus.DWrite;
        latCnt        <= LatLoad;
        dStreak       <= bus.IReq ? dStreak + 2'd1 : 2'd0;
      end else if (done) begin
        bus.MemRead  <= 1'b0;
        bus.MemWrite <= 1'b0;
        if (state == BUSY_I) begin
          bus.IValid  <= 1'b1;
          bus.IRdData <= bus.MemRdData;
        end else begin
          bus.DValid  <= 1'b1;
          bus.DRdData <= bus.MemWrite ? 32'd0 : bus.MemRdData;
        end
      end else if (state != IDLE) begin
        latCnt <= latCnt - 4'd1;
      end
    end
  end

  assign bus.StallF = bus.IReq & ~bus.IValid;
  assign bus.StallM = bus.DReq & ~bus.DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at LATENCY=2, one at LATENCY=1.
module tb_mem_port_arbiter;
  logic Clk;
  logic Reset;
  int   nTests = 0;
  int   nFail  = 0;

  mem_port_arbiter_if b0();
  mem_port_arbiter_if b1();

  mem_port_arbiter #(.LATENCY(2)) u0 (.Clk(Clk), .Reset(Reset), .bus(b0.slave));
  mem_port_arbiter #(.LATENCY(1)) u1 (.Clk(Clk), .Reset(Reset), .bus(b1.slave));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    nTests++; if (b0.MemRead !== 1'b0) begin nFail++; $display("FAIL reset_memread got %b want 0", b0.MemRead); end
    nTests++; if (b0.MemWrite !== 1'b0) begin nFail++; $display("FAIL reset_memwrite got %b want 0", b0.MemWrite); end
    nTests++; if (b0.MemAddr !== 32'd0) begin nFail++; $display("FAIL reset_memaddr got %h want 0", b0.MemAddr); end
    nTests++; if (b0.IValid !== 1'b0 || b0.DValid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b%b want 00", b0.IValid, b0.DValid); end
    nTests++; if (b1.MemRead !== 1'b0) begin nFail++; $display("FAIL reset_l1_memread got %b want 0", b1.MemRead); end
    Reset = 1'b0;
    tick();
    nTests++; if (b0.MemRead !== 1'b0) begin nFail++; $display("FAIL idle_no_grant got %b want 0", b0.MemRead); end
  endtask

  task automatic test_fetch();
    b0.IReq = 1'b1; b0.IAddr = 32'h10; b0.MemRdData = 32'h2002000A;
    #1;
    nTests++; if (b0.StallF !== 1'b1) begin nFail++; $display("FAIL fetch_stall_pre got %b want 1", b0.StallF); end
    for (int c = 0; c < 2; c++) begin
      tick();
      nTests++; if (b0.MemRead !== 1'b1 || b0.MemAddr !== 32'h10 || b0.MemType !== 2'b00)
        begin nFail++; $display("FAIL fetch_busy%0d got rd=%b addr=%h type=%b want 1/10/00", c, b0.MemRead, b0.MemAddr, b0.MemType); end
      nTests++; if (b0.IValid !== 1'b0 || b0.StallF !== 1'b1)
        begin nFail++; $display("FAIL fetch_wait%0d got valid=%b stall=%b want 0/1", c, b0.IValid, b0.StallF); end
    end
    tick();
    nTests++; if (b0.IValid !== 1'b1 || b0.IRdData !== 32'h2002000A)
      begin nFail++; $display("FAIL fetch_valid got valid=%b data=%h want 1/2002000a", b0.IValid, b0.IRdData); end
    nTests++; if (b0.MemRead !== 1'b0 || b0.StallF !== 1'b0)
      begin nFail++; $display("FAIL fetch_done got rd=%b stall=%b want 0/0", b0.MemRead, b0.StallF); end
    b0.IReq = 1'b0; b0.MemRdData = 32'h0;
    tick();
    nTests++; if (b0.IValid !== 1'b0 || b0.MemRead !== 1'b0 || b0.IRdData !== 32'h2002000A)
      begin nFail++; $display("FAIL fetch_after got valid=%b rd=%b data=%h want 0/0/2002000a", b0.IValid, b0.MemRead, b0.IRdData); end
  endtask

  task automatic test_priority();
    b0.IReq = 1'b1; b0.IAddr = 32'h20;
    b0.DReq = 1'b1; b0.DAddr = 32'h40; b0.DWrite = 1'b0; b0.DMemType = 2'b10;
    b0.MemRdData = 32'h11111111;
    for (int c = 0; c < 2; c++) begin
      tick();
      nTests++; if (b0.MemRead !== 1'b1 || b0.MemAddr !== 32'h40 || b0.MemType !== 2'b10 || b0.StallF !== 1'b1)
        begin nFail++; $display("FAIL prio_d_busy%0d got rd=%b addr=%h type=%b stallF=%b want 1/40/10/1", c, b0.MemRead, b0.MemAddr, b0.MemType, b0.StallF); end
    end
    tick();
    nTests++; if (b0.DValid !== 1'b1 || b0.DRdData !== 32'h11111111 || b0.MemRead !== 1'b0 || b0.StallF !== 1'b1)
      begin nFail++; $display("FAIL prio_d_valid got dv=%b data=%h rd=%b stallF=%b want 1/11111111/0/1", b0.DValid, b0.DRdData, b0.MemRead, b0.StallF); end
    b0.DReq = 1'b0; b0.MemRdData = 32'h22222222;
    for (int c = 0; c < 2; c++) begin
      tick();
      nTests++; if (b0.MemRead !== 1'b1 || b0.MemAddr !== 32'h20 || b0.MemType !== 2'b00 || b0.StallF !== 1'b1)
        begin nFail++; $display("FAIL prio_i_busy%0d got rd=%b addr=%h type=%b stallF=%b want 1/20/00/1", c, b0.MemRead, b0.MemAddr, b0.MemType, b0.StallF); end
    end
    tick();
    nTests++; if (b0.IValid !== 1'b1 || b0.IRdData !== 32'h22222222 || b0.DRdData !== 32'h11111111)
      begin nFail++; $display("FAIL prio_i_valid got iv=%b idata=%h ddata=%h want 1/22222222/11111111", b0.IValid, b0.IRdData, b0.DRdData); end
    b0.IReq = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [31:0] expAddr [6];
    logic        prevStrobe;
    int          g;
    expAddr = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};
    prevStrobe = 1'b0;
    g = 0;
    b0.IReq = 1'b1; b0.IAddr = 32'h100;
    b0.DReq = 1'b1; b0.DAddr = 32'h200; b0.DWrite = 1'b0; b0.DMemType = 2'b01;
    for (int c = 0; c < 40 && g < 6; c++) begin
      tick();
      if ((b0.MemRead | b0.MemWrite) && !prevStrobe) begin
        nTests++;
        if (b0.MemAddr !== expAddr[g]) begin nFail++; $display("FAIL starve_grant%0d got addr=%h want %h", g, b0.MemAddr, expAddr[g]); end
        g++;
      end
      prevStrobe = b0.MemRead | b0.MemWrite;
    end
    nTests++; if (g != 6) begin nFail++; $display("FAIL starve_count got %0d grants want 6", g); end
    b0.IReq = 1'b0; b0.DReq = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_store();
    b0.DReq = 1'b1; b0.DWrite = 1'b1; b0.DAddr = 32'h80; b0.DWrData = 32'hDEADBEEF;
    b0.DMemType = 2'b10; b0.MemRdData = 32'h55555555;
    for (int c = 0; c < 2; c++) begin
      tick();
      nTests++; if (b0.MemWrite !== 1'b1 || b0.MemRead !== 1'b0 || b0.MemAddr !== 32'h80 || b0.MemWrData !== 32'hDEADBEEF)
        begin nFail++; $display("FAIL store_busy%0d got wr=%b rd=%b addr=%h wdata=%h want 1/0/80/deadbeef", c, b0.MemWrite, b0.MemRead, b0.MemAddr, b0.MemWrData); end
      nTests++; if (b0.StallM !== 1'b1) begin nFail++; $display("FAIL store_stallm%0d got %b want 1", c, b0.StallM); end
    end
    tick();
    nTests++; if (b0.DValid !== 1'b1 || b0.DRdData !== 32'd0 || b0.MemWrite !== 1'b0 || b0.StallM !== 1'b0)
      begin nFail++; $display("FAIL store_valid got dv=%b data=%h wr=%b stallM=%b want 1/0/0/0", b0.DValid, b0.DRdData, b0.MemWrite, b0.StallM); end
    b0.DReq = 1'b0;
    tick();
  endtask

  task automatic test_drop_midway();
    b0.IReq = 1'b1; b0.IAddr = 32'h50; b0.MemRdData = 32'h0BADF00D;
    tick();
    nTests++; if (b0.MemRead !== 1'b1 || b0.MemAddr !== 32'h50)
      begin nFail++; $display("FAIL drop_grant got rd=%b addr=%h want 1/50", b0.MemRead, b0.MemAddr); end
    b0.IReq = 1'b0;
    tick();
    tick();
    nTests++; if (b0.IValid !== 1'b1 || b0.IRdData !== 32'h0BADF00D)
      begin nFail++; $display("FAIL drop_valid got iv=%b data=%h want 1/0badf00d", b0.IValid, b0.IRdData); end
    tick();
    nTests++; if (b0.MemRead !== 1'b0 || b0.IValid !== 1'b0)
      begin nFail++; $display("FAIL drop_no_regrant got rd=%b iv=%b want 0/0", b0.MemRead, b0.IValid); end
  endtask

  task automatic test_reset_abort();
    b0.DReq = 1'b1; b0.DWrite = 1'b1; b0.DAddr = 32'h84; b0.DWrData = 32'h12345678;
    tick();
    nTests++; if (b0.MemWrite !== 1'b1) begin nFail++; $display("FAIL abort_pre got wr=%b want 1", b0.MemWrite); end
    Reset = 1'b1;
    #1;
    nTests++; if (b0.MemWrite !== 1'b0 || b0.MemAddr !== 32'd0)
      begin nFail++; $display("FAIL abort_async got wr=%b addr=%h want 0/0", b0.MemWrite, b0.MemAddr); end
    tick();
    tick();
    nTests++; if (b0.DValid !== 1'b0 || b0.MemWrite !== 1'b0)
      begin nFail++; $display("FAIL abort_hold got dv=%b wr=%b want 0/0", b0.DValid, b0.MemWrite); end
    Reset = 1'b0;
    tick();
    nTests++; if (b0.MemWrite !== 1'b1 || b0.MemAddr !== 32'h84 || b0.DValid !== 1'b0)
      begin nFail++; $display("FAIL abort_regrant got wr=%b addr=%h dv=%b want 1/84/0", b0.MemWrite, b0.MemAddr, b0.DValid); end
    tick();
    tick();
    nTests++; if (b0.DValid !== 1'b1 || b0.DRdData !== 32'd0)
      begin nFail++; $display("FAIL abort_complete got dv=%b data=%h want 1/0", b0.DValid, b0.DRdData); end
    b0.DReq = 1'b0; b0.DWrite = 1'b0;
    tick();
  endtask

  task automatic test_latency1();
    b1.IReq = 1'b1; b1.IAddr = 32'h30; b1.MemRdData = 32'hCAFEF00D;
    tick();
    nTests++; if (b1.MemRead !== 1'b1 || b1.MemAddr !== 32'h30 || b1.IValid !== 1'b0)
      begin nFail++; $display("FAIL l1_grant got rd=%b addr=%h iv=%b want 1/30/0", b1.MemRead, b1.MemAddr, b1.IValid); end
    tick();
    nTests++; if (b1.IValid !== 1'b1 || b1.IRdData !== 32'hCAFEF00D || b1.MemRead !== 1'b0)
      begin nFail++; $display("FAIL l1_valid got iv=%b data=%h rd=%b want 1/cafef00d/0", b1.IValid, b1.IRdData, b1.MemRead); end
    b1.IReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nTests++; if (b1.MemRead !== 1'b0 || b1.MemWrite !== 1'b0 || b1.IValid !== 1'b0)
        begin nFail++; $display("FAIL l1_gap%0d got rd=%b wr=%b iv=%b want 0/0/0", c, b1.MemRead, b1.MemWrite, b1.IValid); end
    end
    b1.DReq = 1'b1; b1.DAddr = 32'h34; b1.DWrite = 1'b0; b1.DMemType = 2'b01; b1.MemRdData = 32'h00C0FFEE;
    tick();
    nTests++; if (b1.MemRead !== 1'b1 || b1.MemAddr !== 32'h34 || b1.MemType !== 2'b01)
      begin nFail++; $display("FAIL l1_dgrant got rd=%b addr=%h type=%b want 1/34/01", b1.MemRead, b1.MemAddr, b1.MemType); end
    tick();
    nTests++; if (b1.DValid !== 1'b1 || b1.DRdData !== 32'h00C0FFEE)
      begin nFail++; $display("FAIL l1_dvalid got dv=%b data=%h want 1/00c0ffee", b1.DValid, b1.DRdData); end
    b1.DReq = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    b0.IReq = 1'b0; b0.IAddr = '0; b0.DReq = 1'b0; b0.DAddr = '0; b0.DWrData = '0;
    b0.DWrite = 1'b0; b0.DMemType = '0; b0.MemRdData = '0;
    b1.IReq = 1'b0; b1.IAddr = '0; b1.DReq = 1'b0; b1.DAddr = '0; b1.DWrData = '0;
    b1.DWrite = 1'b0; b1.DMemType = '0; b1.MemRdData = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_drop_midway();
    test_reset_abort();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: LATENCY, default 2, the number of cycles from grant to response (legal range 1-15).
REQ-002 Clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 IReq  in  1  fetch-side read request, held high until IValid.
REQ-005 IAddr  in  32  fetch address, held stable while IReq is high.
REQ-006 DReq  in  1  data-side request, held high until DValid.
REQ-007 DAddr  in  32  data address.
REQ-008 DWrData  in  32  store data.
REQ-009 DWrite  in  1  1 = store, 0 = load.
REQ-010 DMemType  in  2  access size, passed through to memory.
REQ-011 MemRdData  in  32  read data from the shared single-port memory.
REQ-012 MemAddr  out  32  address presented to the memory.
REQ-013 MemWrData  out  32  write data presented to the memory.
REQ-014 MemRead  out  1  memory read strobe.
REQ-015 MemWrite  out  1  memory write strobe.
REQ-016 MemType  out  2  access size presented to the memory.
REQ-017 IValid  out  1  one-cycle fetch completion pulse.
REQ-018 IRdData  out  32  fetched instruction, valid when IValid is high.
REQ-019 DValid  out  1  one-cycle data completion pulse.
REQ-020 DRdData  out  32  load data, valid when DValid is high.
REQ-021 StallF  out  1  combinational: IReq & ~IValid.
REQ-022 StallM  out  1  combinational: DReq & ~DValid.

Function
REQ-023 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-024 In IDLE, DReq SHALL take priority: IDLE->BUSY_D if DReq, else IDLE->BUSY_I if IReq, else stay in IDLE.
REQ-025 Starvation guard: a 2-bit DStreak SHALL count consecutive D grants made while IReq was high; when IReq & DReq and DStreak==2, the block SHALL grant I and clear DStreak.
REQ-026 Any I grant, and any D grant made while IReq is low, SHALL clear DStreak.
REQ-027 On a grant edge, the requester's address, data, write and type SHALL be registered onto Mem* and held constant for the whole BUSY period.
REQ-028 MemRead SHALL be high for the whole BUSY period in BUSY_I, and in BUSY_D when DWrite=0.
REQ-029 MemWrite SHALL be high for the whole BUSY period in BUSY_D when DWrite=1.
REQ-030 MemType SHALL be 2'b00 for fetches.
REQ-031 On a grant, a latency counter SHALL load LATENCY-1 and decrement once per cycle in BUSY.
REQ-032 In the BUSY cycle where the counter is 0 (the completion cycle), MemRdData SHALL be registered into IRdData/DRdData, the matching Valid SHALL pulse high for exactly the next cycle, and the FSM SHALL return to IDLE.
REQ-033 Latency: a request that is granted from IDLE at edge N SHALL produce its Valid pulse during cycle N+LATENCY.
REQ-034 There SHALL be no back-to-back grant; at least one IDLE cycle SHALL separate transactions.
REQ-035 A store SHALL drive DRdData to 0 at its DValid pulse.
REQ-036 IRdData/DRdData SHALL hold their values until the next completion for that port.
REQ-037 If a Req drops mid-transaction, the transaction SHALL complete and Valid SHALL still pulse; the FSM SHALL NOT issue a grant in the IDLE cycle coinciding with that Valid for the same port.
REQ-038 MemRead and MemWrite SHALL never be high simultaneously.
REQ-039 Mem strobes SHALL be low in IDLE.

Reset
REQ-040 Reset SHALL immediately set the FSM to IDLE and clear the counter and DStreak; all outputs SHALL go to 0, including mid-transaction (the transaction is aborted and no Valid is issued).
REQ-041 After Reset deasserts, the first grant SHALL occur at the first rising edge that sees a request.

Verification
REQ-042 LATENCY=2, IReq with IAddr=0x10 and MemRdData=0x2002000A -> MemRead with MemAddr=0x10 for 2 cycles, IValid one cycle with IRdData=0x2002000A, StallF high until then.
REQ-043 IReq and DReq raised in the same cycle (DAddr=0x40, load) -> D is served first, then one IDLE cycle, then I; StallF is high throughout.
REQ-044 Continuous DReq and IReq -> grant order D, D, I, D, D, I; I is never waiting longer than 2 D transactions.
REQ-045 Store with DAddr=0x80 and DWrData=0xDEADBEEF -> MemWrite high for 2 cycles with the values held, MemRead low, DValid pulse with DRdData=0.
REQ-046 Reset asserted in the 1st BUSY cycle of a store -> MemWrite drops without waiting for a clock edge; no DValid; after release, the pending DReq is re-granted from IDLE.
REQ-047 LATENCY=1 -> Valid pulses in the cycle after the grant; a 3-cycle IReq gap leaves Mem* strobes low.
